sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Shares the single port of the large embedded SRAM between the AHB-Lite SRAM interface (port A) and a secondary requester such as a DMA or scrubber (port B).
After reset it first runs an optional memory-clear sequence. It then arbitrates per cycle: port A has priority, and a starvation limit guarantees port B service.
It steers the 1-cycle-latency read data back to whichever port issued the read, and drives the BUSY stall input of the AHB interface.

Parameters:
MEM_AWIDTH, 19, width of the memory word address on all ports.
INIT_EN, 1, 1 = clear memory after reset; 0 = skip the clear.
INIT_WORDS, 1024, number of words cleared, starting at address 0 (1..2**MEM_AWIDTH).
INIT_VALUE, 32'h0, data written during the clear.
STARVE_LIMIT, 8, maximum number of consecutive cycles port B may wait (>=1).

Ports:
HCLK  in  1  clock; all logic on the rising edge
HRESET  in  1  synchronous, active-high reset
a_write  in  1  port A write strobe
a_read  in  1  port A read strobe
a_addr  in  MEM_AWIDTH  port A word address
a_wdata  in  32  port A write data
a_byteen  in  4  port A byte enables (writes only)
a_rdata  out  32  port A read data
a_busy  out  1  registered stall to port A (feeds AHB interface BUSY)
b_req  in  1  port B request; held until granted
b_write  in  1  1 = write, 0 = read; qualified by b_req
b_addr  in  MEM_AWIDTH  port B word address
b_wdata  in  32  port B write data
b_byteen  in  4  port B byte enables
b_gnt  out  1  combinational grant, 1 cycle; the command is taken that cycle
b_rvalid  out  1  pulse: b_rdata is valid
b_rdata  out  32  port B read data
mem_ren  out  1  SRAM read enable
mem_wen  out  4  SRAM byte write enables
mem_addr  out  MEM_AWIDTH  SRAM address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid 1 cycle after mem_ren
init_done  out  1  memory clear complete
a_viol  out  1  sticky: port A issued a command while a_busy=1

Behaviour:
- Reset values: all outputs 0, except a_busy=1 when INIT_EN=1. The state machine goes to INIT (INIT_EN=1) or RUN (INIT_EN=0). The address counter, starvation counter, owner flag and hold registers are all cleared.
- HRESET asserted in any state, including mid-INIT, aborts the current activity and restarts from the reset state. There is no partial-state retention.
- INIT:
  - One write per cycle: mem_wen=4'hF, mem_addr=counter, mem_wdata=INIT_VALUE.
  - After the write to INIT_WORDS-1: go to RUN, set init_done=1 and a_busy=0 on the next edge.
  - a_busy=1 throughout INIT. b_gnt=0.
- RUN: mux select, per cycle, combinational:
  1. a_busy=0 and (a_read or a_write): port A drives the memory.
     - mem_ren=a_read & ~a_write.
     - mem_wen = a_write ? a_byteen : 0.
     - a_write wins if both strobes are high.
  2. Else if b_req: port B drives the memory and b_gnt=1.
  3. Else the memory is idle: mem_ren=0, mem_wen=0, and addr/wdata hold their last values.
- a_busy scheduling (registered):
  - A starvation counter increments on each cycle where b_req=1 and b_gnt=0; it clears on b_gnt or when b_req=0.
  - When the next value of the counter reaches STARVE_LIMIT, a_busy=1 for exactly one cycle. In that cycle B is granted, because A is blocked.
  - a_busy then returns to 0. The worst-case B wait is STARVE_LIMIT+1 cycles.
- A command from A while a_busy=1 is ignored (no memory access) and sets a_viol. a_viol clears only on reset.
- Read return:
  - A registered owner flag records which port issued the read.
  - One cycle after mem_ren: owner A -> a_rdata = mem_rdata (pass-through); owner B -> b_rdata = mem_rdata and b_rvalid=1.
  - Each of a_rdata and b_rdata holds its last returned value otherwise (hold register, updated only on its own return).
- Back-to-back reads from alternating ports are supported with no bubble; the return path tracks the owner flag every cycle.
- Writes complete in the issue cycle. There is no write-to-read forwarding; the SRAM's read-during-write behaviour applies.

Decomposition:
- Shared package: state encoding (ST_INIT, ST_RUN), the owner encoding (OWN_A, OWN_B), and the clear-value constant.
- One natural sub-module: sram_init_seq. It contains the address counter, done flag and write strobe for the clear sequence; the top level holds the arbitration and return path.

Test Plan:
- Init: INIT_EN=1, INIT_WORDS=16, release reset -> 16 consecutive cycles of mem_wen=F at addr 0..15 with data 0; init_done rises on cycle 17; a_busy falls in the same cycle; b_req held during init is not granted until then.
- A priority: a_read@0x10 and b_req read@0x20 in the same RUN cycle -> mem_addr=0x10; a_rdata=mem_rdata the next cycle; b_gnt=0.
- Starvation: STARVE_LIMIT=4, A reads every cycle, b_req write@0x5 held -> a_busy pulses 1 cycle; b_gnt=1 in that cycle with mem_wen=b_byteen at addr 0x5; total B wait <=5 cycles.
- Interleaved reads: A read@1 (data 0xAAAA0001), next cycle B read@2 (data 0xBBBB0002) -> a_rdata=0xAAAA0001 then holds; b_rvalid pulses once with b_rdata=0xBBBB0002.
- Violation: drive a_write while a_busy=1 -> mem_wen=0 that cycle; a_viol=1 and stays 1 until HRESET.
- Reset mid-init: assert HRESET at INIT address 7 -> init restarts from address 0; init_done stays 0 until a full INIT_WORDS pass completes.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
// Holds the controller state encoding, the read-owner encoding and the default
// value written by the post-reset memory clear.
package sram_port_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam logic [31:0] CLEAR_VALUE = 32'h0000_0000;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester ports and the SRAM port of the arbiter.
//   port A : a_write/a_read/a_addr/a_wdata/a_byteen in, a_rdata/a_busy/a_viol out
//   port B : b_req/b_write/b_addr/b_wdata/b_byteen in, b_gnt/b_rvalid/b_rdata out
//   SRAM   : mem_ren/mem_wen/mem_addr/mem_wdata out, mem_rdata in
//   status : init_done out
// slave  = the arbiter side, master = requesters plus the SRAM macro.
interface sram_port_arbiter_if #(
    parameter int unsigned MEM_AWIDTH = 19
);
    logic                  a_write;
    logic                  a_read;
    logic [MEM_AWIDTH-1:0] a_addr;
    logic [31:0]           a_wdata;
    logic [3:0]            a_byteen;
    logic [31:0]           a_rdata;
    logic                  a_busy;
    logic                  a_viol;

    logic                  b_req;
    logic                  b_write;
    logic [MEM_AWIDTH-1:0] b_addr;
    logic [31:0]           b_wdata;
    logic [3:0]            b_byteen;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [31:0]           b_rdata;

    logic                  mem_ren;
    logic [3:0]            mem_wen;
    logic [MEM_AWIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    logic                  init_done;

    modport slave (
        input  a_write, a_read, a_addr, a_wdata, a_byteen,
        input  b_req, b_write, b_addr, b_wdata, b_byteen,
        input  mem_rdata,
        output a_rdata, a_busy, a_viol,
        output b_gnt, b_rvalid, b_rdata,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        output init_done
    );

    modport master (
        output a_write, a_read, a_addr, a_wdata, a_byteen,
        output b_req, b_write, b_addr, b_wdata, b_byteen,
        output mem_rdata,
        input  a_rdata, a_busy, a_viol,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        input  init_done
    );

endinterface

// File: rtl/sram_init_seq.sv
// Memory-clear sequencer: walks addresses 0..INIT_WORDS-1, one word per cycle.
//   clk, rst : clock and synchronous active-high reset
//   en       : sequence runs while high (controller in its clear state)
//   addr     : word address to clear this cycle
//   wen      : clear write strobe
//   last     : this cycle writes the final word
//   done     : registered, sticky once the clear has finished or was skipped
module sram_init_seq
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH = 19,
    parameter int unsigned INIT_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [MEM_AWIDTH-1:0] addr,
    output logic                  wen,
    output logic                  last,
    output logic                  done
);

    localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(INIT_WORDS - 1);

    logic [MEM_AWIDTH-1:0] cnt_q;
    logic                  done_q;

    assign addr = cnt_q;
    assign wen  = en;
    assign last = en && (cnt_q == LAST_ADDR);
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (en) begin
                cnt_q <= last ? '0 : cnt_q + MEM_AWIDTH'(1);
            end
            // Leaving the clear state (or never entering it) means the memory is ready.
            done_q <= done_q | last | ~en;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: AHB-side port A (priority) and secondary port B.
//   HCLK, HRESET : clock and synchronous active-high reset
//   bus          : slave side of sram_port_arbiter_if (requester ports + SRAM port)
// After reset an optional clear sequence fills the memory, then the port is
// arbitrated per cycle with a starvation limit guaranteeing B service. Read
// data returns one cycle after mem_ren to whichever port issued the read.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH   = 19,
    parameter bit          INIT_EN      = 1'b1,
    parameter int unsigned INIT_WORDS   = 1024,
    parameter logic [31:0] INIT_VALUE   = CLEAR_VALUE,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                HCLK,
    input logic                HRESET,
    sram_port_arbiter_if.slave bus
);

    localparam int unsigned    SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    state_e                st_q, st_d;
    logic                  a_busy_q, a_busy_d;
    logic                  a_viol_q;
    logic [SW-1:0]         starve_q, starve_d;
    owner_e                owner_q;
    logic                  rd_pend_q;
    logic [31:0]           a_hold_q, b_hold_q;
    logic [MEM_AWIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  init_wen, init_last, init_done;
    logic [MEM_AWIDTH-1:0] init_addr;

    logic                  a_cmd, a_sel, b_sel;
    logic                  mem_ren;
    logic [3:0]            mem_wen;
    logic [MEM_AWIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  a_ret, b_ret;
    logic [31:0]           a_rdata, b_rdata;

    sram_init_seq #(
        .MEM_AWIDTH (MEM_AWIDTH),
        .INIT_WORDS (INIT_WORDS)
    ) u_init_seq (
        .clk  (HCLK),
        .rst  (HRESET),
        .en   (st_q == ST_INIT),
        .addr (init_addr),
        .wen  (init_wen),
        .last (init_last),
        .done (init_done)
    );

    assign a_cmd = bus.a_read | bus.a_write;

    // Memory mux, grant and next-state. Everything is forced idle while HRESET
    // is high so the SRAM sees no access during reset.
    always_comb begin
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 4'h0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        st_d      = st_q;
        a_busy_d  = a_busy_q;
        starve_d  = '0;
        if (!HRESET) begin
            case (st_q)
                ST_INIT: begin
                    mem_wen   = {4{init_wen}};
                    mem_addr  = init_addr;
                    mem_wdata = INIT_VALUE;
                    a_busy_d  = 1'b1;
                    if (init_last) begin
                        st_d     = ST_RUN;
                        a_busy_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!a_busy_q && a_cmd) begin
                        a_sel     = 1'b1;
                        mem_ren   = bus.a_read & ~bus.a_write;
                        mem_wen   = bus.a_write ? bus.a_byteen : 4'h0;
                        mem_addr  = bus.a_addr;
                        mem_wdata = bus.a_wdata;
                    end else if (bus.b_req) begin
                        b_sel     = 1'b1;
                        mem_ren   = ~bus.b_write;
                        mem_wen   = bus.b_write ? bus.b_byteen : 4'h0;
                        mem_addr  = bus.b_addr;
                        mem_wdata = bus.b_wdata;
                    end
                    // Counter never passes the limit: the busy pulse forces a grant.
                    if (bus.b_req && !b_sel) begin
                        starve_d = starve_q + SW'(1);
                    end
                    a_busy_d = (starve_d == STARVE_MAX);
                end
                default: ;
            endcase
        end
    end

    // Return path: pass-through in the cycle after the read, hold otherwise.
    always_comb begin
        a_ret   = rd_pend_q && (owner_q == OWN_A);
        b_ret   = rd_pend_q && (owner_q == OWN_B);
        a_rdata = a_ret ? bus.mem_rdata : a_hold_q;
        b_rdata = b_ret ? bus.mem_rdata : b_hold_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st_q      <= INIT_EN ? ST_INIT : ST_RUN;
            a_busy_q  <= INIT_EN;
            a_viol_q  <= 1'b0;
            starve_q  <= '0;
            owner_q   <= OWN_A;
            rd_pend_q <= 1'b0;
            a_hold_q  <= '0;
            b_hold_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            st_q      <= st_d;
            a_busy_q  <= a_busy_d;
            starve_q  <= starve_d;
            if (a_cmd && a_busy_q) begin
                a_viol_q <= 1'b1;
            end
            rd_pend_q <= mem_ren;
            if (mem_ren) begin
                owner_q <= a_sel ? OWN_A : OWN_B;
            end
            a_hold_q  <= a_rdata;
            b_hold_q  <= b_rdata;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
        end
    end

    assign bus.a_rdata   = a_rdata;
    assign bus.a_busy    = a_busy_q;
    assign bus.a_viol    = a_viol_q;
    assign bus.b_gnt     = b_sel;
    assign bus.b_rvalid  = b_ret;
    assign bus.b_rdata   = b_rdata;
    assign bus.mem_ren   = mem_ren;
    assign bus.mem_wen   = mem_wen;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.init_done = init_done;

endmodule
